// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_unit                                                     |
// | In-order fetch stage: PC, credit-limited imem requests, {pc,word} FIFO.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus_4
);

  localparam int unsigned c_PW = $clog2(DEPTH);
  localparam int unsigned c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW:0]   c_DEPTH_SUM = DEPTH[c_CW:0];
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop;
  logic [c_CW-1:0] r_count;
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [31:0]     r_fifo_word [DEPTH];

  logic            w_req;
  logic            w_issue;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [c_CW:0]   w_sum;
  logic [c_CW-1:0] w_out_next;
  logic [31:0]     w_redirect_pc;
  logic [31:0]     w_id_pc;
  logic            w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};

  // Credit covers both buffered and in-flight words, so a push never overflows.
  assign w_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req   = rst_n && !redirect && (w_sum < c_DEPTH_SUM);
  assign w_issue = w_req && imem_ready;
  // A response with nothing outstanding is a memory protocol error and is ignored.
  assign w_resp  = imem_rvalid && (r_outstanding != '0);
  assign w_push  = w_resp && !redirect && (r_drop == '0);
  assign w_valid = (r_count != '0) && !redirect;
  assign w_pop   = w_valid && id_ready;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_issue) w_out_next = w_out_next + c_CNT_ONE;
    if (w_resp)  w_out_next = w_out_next - c_CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (redirect) begin
      // Every request still in flight belongs to the old stream.
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= w_out_next;
      r_drop        <= w_out_next;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= w_out_next;
      if (w_resp && (r_drop != '0)) r_drop <= r_drop - c_CNT_ONE;
      if (w_push) begin
        r_wptr    <= r_wptr + c_PTR_ONE;
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]   <= r_resp_pc;
      r_fifo_word[r_wptr] <= imem_rdata;
    end
  end

  assign w_id_pc        = (r_count != '0) ? r_fifo_pc[r_rptr] : r_resp_pc;
  assign imem_req       = w_req;
  assign imem_addr      = r_fetch_pc;
  assign id_valid       = w_valid;
  assign id_instruction = w_valid ? r_fifo_word[r_rptr] : NOP;
  assign id_pc          = w_id_pc;
  assign id_pc_plus_4   = w_id_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch_unit                                                  |
// | Randomized bench with memory model, stream reference model and scoreboard. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
  localparam int          c_DEPTH    = 4;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;

  instruction_fetch_unit #(
    .RESET_PC(c_RESET_PC),
    .DEPTH   (c_DEPTH),
    .NOP     (c_NOP)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instruction(id_instruction),
    .id_pc         (id_pc),
    .id_pc_plus_4  (id_pc_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    bit          arrived;
  } exp_t;

  int          errors    = 0;
  int          checks    = 0;
  int          cyc       = 0;
  int          lat       = 1;
  int          epoch     = 0;
  int          delivered = 0;
  bit          mon_en    = 1'b0;
  logic [31:0] req_pc;
  mem_t        mem_q[$];
  exp_t        exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: in-order responses, each request returns after its own latency.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (mon_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
    end
  end

  // Monitor / scoreboard: sampled mid-cycle, models advanced as if at the edge.
  always begin
    @(negedge clk);
    if (mon_en) begin
      int   stale;
      bit   exp_req;
      bit   exp_valid;
      bit   marked;
      mem_t m;
      exp_t e;
      #3;
      stale = 0;
      foreach (mem_q[j]) if (mem_q[j].epoch != epoch) stale++;
      exp_req = !redirect && ((exp_q.size() + stale) < c_DEPTH);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, req_pc);
      exp_valid = !redirect && exp_q.size() > 0 && exp_q[0].arrived;
      check("id_valid", 32'(id_valid), 32'(exp_valid));
      if (!id_valid) check("id_instruction_nop", id_instruction, c_NOP);
      if (exp_valid && id_ready) begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_instruction", id_instruction, word_of(e.pc));
        check("id_pc_plus_4", id_pc_plus_4, e.pc + 32'd4);
        delivered++;
      end
      if (imem_rvalid) begin
        m = mem_q.pop_front();
        if (!redirect && m.epoch == epoch) begin
          marked = 1'b0;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (!marked && !exp_q[j].arrived) begin
              exp_q[j].arrived = 1'b1;
              marked = 1'b1;
            end
          end
        end
      end
      if (redirect) begin
        epoch++;
        exp_q.delete();
        req_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req && imem_ready) begin
        mem_q.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
        exp_q.push_back('{pc: req_pc, arrived: 1'b0});
        req_pc = req_pc + 32'd4;
      end
    end
  end

  task automatic run(input int n, input int idr_pct, input int imr_pct, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      id_ready   = ($urandom_range(99) < idr_pct);
      imem_ready = ($urandom_range(99) < imr_pct);
      if (!redirect && ($urandom_range(99) < rd_pct)) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect = 1'b0;
      end
    end
  endtask

  task automatic force_redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = pc;
    id_ready    = 1'b1;
    imem_ready  = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    req_pc      = c_RESET_PC;

    repeat (3) @(negedge clk);
    #3;
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_imem_addr", imem_addr, c_RESET_PC);
    check("reset_id_valid", 32'(id_valid), 32'd0);
    check("reset_id_instruction", id_instruction, c_NOP);
    check("reset_id_pc", id_pc, c_RESET_PC);
    check("reset_id_pc_plus_4", id_pc_plus_4, c_RESET_PC + 32'd4);

    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    mon_en     = 1'b1;

    run(30, 100, 100, 0);
    run(6, 0, 100, 0);
    run(10, 100, 100, 0);
    run(3, 100, 0, 0);
    run(10, 100, 100, 0);

    lat = 3;
    run(12, 100, 100, 0);
    force_redirect(32'h0000_2002);
    run(20, 100, 100, 0);

    lat = 1;
    run(10, 100, 100, 0);
    force_redirect(32'h0000_4000);
    run(10, 100, 100, 0);

    force_redirect(32'hFFFF_FFF4);
    run(15, 100, 100, 0);

    for (int b = 0; b < 8; b++) begin
      lat = $urandom_range(4, 1);
      run(80, 75, 70, 5);
    end
    lat = 1;
    run(30, 100, 100, 0);

    check("stream_progress", 32'(delivered >= 150), 32'd1);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset_imem_req", 32'(imem_req), 32'd0);
    check("async_reset_id_valid", 32'(id_valid), 32'd0);
    check("async_reset_imem_addr", imem_addr, c_RESET_PC);
    check("async_reset_id_pc", id_pc, c_RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that produces the instruction stream consumed by the instruction decoder. It owns the program counter, issues in-order requests to instruction memory over a valid/ready request channel, and buffers returned words with their PCs in a small FIFO. It presents instruction/PC pairs to the decode stage and handles stalls from decode and redirects (taken branch, jal, jalr) from execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, FIFO entries and maximum outstanding credit; power of two, ≥2
- NOP, 32'h0000_0013, word driven on id_instruction when id_valid is low (addi x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse: discard the stream and restart at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0)
- id_ready  in  1  decode accepts this cycle; low = stall
- id_valid  out  1  id_* hold a valid instruction
- id_instruction  out  32  instruction word, or NOP when id_valid is low
- id_pc  out  32  address of id_instruction
- id_pc_plus_4  out  32  id_pc + 4, mod 2^32

## Operation
- State: fetch_pc (32), outstanding (0..DEPTH), drop (0..DEPTH), and a FIFO of {pc, word} with wrap-around read/write pointers plus a count.
- Issue: imem_req = !redirect && (outstanding + fifo_count < DEPTH). imem_addr = fetch_pc. On imem_req && imem_ready: fetch_pc += 4 (wraps at 2^32), outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1. If drop > 0, drop -= 1 and the word is discarded. Otherwise push {pc, imem_rdata} into the FIFO. The pc comes from a pc-tag queue or counter maintained in issue order.
- Output: id_* show the FIFO head. id_valid = fifo_count > 0 && !redirect. Pop on id_valid && id_ready.
- Redirect cycle: no issue and no pop. Next state: fetch_pc = {redirect_pc[31:2],2'b00}, FIFO emptied, drop = outstanding − imem_rvalid. A response arriving in the redirect cycle is discarded.
- Credit rule: fifo_count + outstanding ≤ DEPTH at all times, so a push never finds the FIFO full. Simultaneous push and pop keep the count unchanged.
- Redirect while drop > 0: drop is recomputed with the same formula; stale words keep being discarded.
- imem_rvalid with outstanding == 0 is a protocol error. The counter saturates at 0 and the word is ignored.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, id_valid 0, id_instruction NOP, id_pc RESET_PC, id_pc_plus_4 RESET_PC+4. All counters are 0 and the FIFO is empty.
- First imem_req=1 in the first clock edge cycle after rst_n deasserts.
- Reset asserted mid-operation clears all state immediately, regardless of clock. In-flight responses after reset release are the memory's responsibility; the memory must be reset together with this block.
- While imem_req=1 and imem_ready=0, imem_addr is held stable. It changes only after acceptance or after a redirect.
- Latency: a response at cycle t reaches id_valid at t+1, because the FIFO is registered with no bypass.
- Redirect at T: request for redirect_pc at T+1. With a 1-cycle memory, id_valid for it at T+3.
- Throughput: DEPTH=4 with 1-cycle memory and id_ready=1 sustains one instruction per cycle.
- Stall: while id_ready=0, the id_* outputs hold. Issue stops once fifo_count + outstanding reaches DEPTH.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory returning addr-derived words, id_ready=1 -> requests at 0x100, 0x104, 0x108…; id_pc 0x100 at the 3rd cycle after release, then one instruction per cycle.
- id_ready low for 6 cycles mid-stream -> id_* frozen; at most 4 words buffered or outstanding; no request beyond credit; resume with no gap or duplicate PCs.
- imem_ready low for 3 cycles with imem_req high -> imem_addr stable; no PC skipped.
- 3-cycle memory, redirect to 0x2002 with 3 outstanding -> 3 stale responses dropped; next id_pc is 0x2000, then 0x2004.
- Redirect in the same cycle as imem_rvalid and an id_ready pop -> no pop, that word discarded, drop = outstanding−1; the new stream is clean.
- fetch_pc = 0xFFFF_FFFC -> next request 0x0000_0000; id_pc_plus_4 = 0x0000_0000 for 0xFFFF_FFFC.
